fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Drain stage on the read side of the status FIFO. Watches the FIFO fill count and pulls fixed-length bursts.
//  Presents each burst as framed beats (sob/eob) on a registered valid/ready master stream.
//  Sits between fifo_ctrl/register file and a burst-oriented consumer (e.g. DMA or UART packetiser).
// PARAMETERS
//  DATA_WIDTH  8   FIFO word / stream data width
//  ADDR_WIDTH  4   FIFO address width; fifo_count is ADDR_WIDTH+1 bits
//  BURST_LEN   4   beats per full burst; legal range 1..2**ADDR_WIDTH
//  TIMEOUT     16  idle cycles before a partial burst is flushed; used only with FLUSH_TIMEOUT_EN; >=1
// PORTS
//  clk           in   1             rising-edge clock
//  arst          in   1             asynchronous reset, active-high
//  fifo_rd_data  in   DATA_WIDTH    FIFO head word; valid whenever fifo_empty=0 (fall-through read)
//  fifo_empty    in   1             FIFO empty flag
//  fifo_count    in   ADDR_WIDTH+1  FIFO occupancy
//  fifo_rd_en    out  1             pop request; combinational
//  m_data        out  DATA_WIDTH    stream data; registered
//  m_valid       out  1             stream valid; registered
//  m_ready       in   1             stream ready from consumer
//  m_sob         out  1             first beat of burst; qualified by m_valid
//  m_eob         out  1             last beat of burst; qualified by m_valid
//  busy          out  1             1 while state=BURST or m_valid=1
//  burst_cnt     out  16            count of completed bursts (eob handshakes); wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (arst=1, takes effect immediately and may occur mid-burst):
//   state=IDLE; m_data=0; m_valid=m_sob=m_eob=0; burst_cnt=0; beats_left=0; timer=0; fifo_rd_en=0.
//   Any partial burst is abandoned; no recovery of popped words.
//  FSM states: IDLE, BURST.
//  IDLE -> BURST when fifo_count >= BURST_LEN.
//   On that transition, latch beats_left=BURST_LEN and first_beat=1.
//  BURST stays in BURST while beats_left != 0.
//   Returns to IDLE in the cycle the last beat is loaded into the output register; it does not wait for that beat's handshake.
//  Output register is free when m_valid=0 or (m_valid & m_ready).
//  Load condition:
//   fifo_rd_en = (state==BURST) & (beats_left!=0) & !fifo_empty & out_reg_free.
//   When fifo_rd_en=1, on the next edge:
//    m_data<=fifo_rd_data; m_valid<=1;
//    m_sob<=first_beat; m_eob<=(beats_left==1);
//    beats_left-=1; first_beat<=0.
//  If m_valid & m_ready and no load happens, then m_valid<=0 and m_sob/m_eob<=0.
//  Latency:
//   Burst trigger to first fifo_rd_en: 1 cycle.
//   fifo_rd_en to m_valid: 1 cycle.
//   Throughput: 1 beat/cycle with m_ready held high.
//  fifo_rd_en is never asserted while fifo_empty=1.
//   This is mandatory: the FIFO advances both pointers unconditionally on simultaneous wr_en & rd_en, even when empty.
//  If the FIFO underflows mid-burst (fifo_empty=1), the block stalls in BURST with beats_left held until data arrives.
//  m_data, m_sob and m_eob stay stable while m_valid=1 & m_ready=0.
//  burst_cnt increments on m_valid & m_ready & m_eob.
//  A new burst may start in IDLE while the previous eob beat is still waiting for its handshake.
//   Its first load waits for out_reg_free.
//  Widths:
//   beats_left is $clog2(BURST_LEN+1) bits.
//   Comparisons against fifo_count use ADDR_WIDTH+1 bits.
// CONFIGURATION
//  FLUSH_TIMEOUT_EN defined:
//   In IDLE, timer increments each cycle while 0 < fifo_count < BURST_LEN.
//   timer clears when fifo_count==0, when fifo_count>=BURST_LEN, or on entering BURST.
//   When timer reaches TIMEOUT-1 and the FIFO is still non-empty, the block enters BURST with beats_left=fifo_count (a partial burst).
//   The partial burst is framed with m_sob/m_eob exactly like a full burst.
//   A full-burst trigger takes priority over the timeout in the same cycle.
//  FLUSH_TIMEOUT_EN undefined:
//   No timer logic is built; TIMEOUT is ignored.
//   Residual words below BURST_LEN stay in the FIFO indefinitely.
// TESTING
//  T1 reset: hold arst=1 for 3 cycles with fifo_count=8
//   -> fifo_rd_en=0, m_valid=0, burst_cnt=0 throughout.
//  T2 full burst: FIFO holds 0xA0..0xA3, m_ready=1
//   -> 4 beats on consecutive cycles; sob on 0xA0, eob on 0xA3; burst_cnt=1; 4 fifo_rd_en pulses.
//  T3 backpressure: as T2 but m_ready=0 for 5 cycles after first valid
//   -> m_data=0xA0 held stable; 0 extra pops; all 4 beats delivered in order afterwards.
//  T4 underflow stall: count=4 triggers the burst, but the FIFO is driven empty after 2 pops, then 2 words are written
//   -> fifo_rd_en never asserted while empty; eob on 4th beat.
//  T5 flush (FLUSH_TIMEOUT_EN, TIMEOUT=16): write 3 words, then idle
//   -> burst of 3 beats starts 16 cycles later; sob on beat 1, eob on beat 3.
//   Without the macro, the same stimulus gives no output after 100 cycles.
//  T6 async reset mid-burst: assert arst after beat 2 of 4
//   -> m_valid=0 immediately; after release state=IDLE; the next burst starts only once fifo_count>=4.

Source files
------------

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Pulls fixed-length bursts from a fall-through FIFO and emits
//                them as sob/eob framed beats on a registered valid/ready
//                stream. Optional partial-burst flush: FLUSH_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sob,
    output logic                  m_eob,
    output logic                  busy,
    output logic [15:0]           burst_cnt
);

    localparam int                    c_BEATS_W   = $clog2(BURST_LEN + 1);
    localparam logic [c_BEATS_W-1:0]  c_BL_BEATS  = c_BEATS_W'(BURST_LEN);
    localparam logic [c_BEATS_W-1:0]  c_ONE_BEAT  = c_BEATS_W'(1);
    localparam logic [ADDR_WIDTH:0]   c_BL_COUNT  = (ADDR_WIDTH + 1)'(BURST_LEN);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    if (BURST_LEN < 1 || BURST_LEN > (1 << ADDR_WIDTH)) begin : g_bad_burst_len
        $error("fifo_burst_reader: BURST_LEN out of range");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fifo_burst_reader: TIMEOUT must be >= 1");
    end

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_BEATS_W-1:0]  r_beats_left;
    logic [c_BEATS_W-1:0]  w_beats_init;
    logic                  r_first_beat;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic                  r_m_sob;
    logic                  r_m_eob;
    logic [15:0]           r_burst_cnt;
    logic                  w_out_free;
    logic                  w_full_trig;
    logic                  w_flush_trig;

    assign w_out_free  = !r_m_valid || m_ready;
    assign w_full_trig = (r_state == c_IDLE) && (fifo_count >= c_BL_COUNT);

`ifdef FLUSH_TIMEOUT_EN
    localparam int                  c_TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMR_W-1:0]  c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    logic [c_TMR_W-1:0] r_timer;

    // A full burst wins over the timeout when both fire in the same cycle.
    assign w_flush_trig = (r_state == c_IDLE) && !w_full_trig &&
                          (fifo_count != '0) && (r_timer == c_TMR_LAST);
    assign w_beats_init = w_full_trig ? c_BL_BEATS : c_BEATS_W'(fifo_count);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_timer <= '0;
        end else if ((r_state != c_IDLE) || (fifo_count == '0) ||
                     w_full_trig || w_flush_trig) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_TMR_W'(1);
        end
    end
`else
    assign w_flush_trig = 1'b0;
    assign w_beats_init = c_BL_BEATS;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leave BURST as soon as the last beat is loaded, not when it is accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_full_trig || w_flush_trig) begin
                    w_state_nxt = c_BURST;
                end
            end
            c_BURST: begin
                if ((r_beats_left == '0) || (fifo_rd_en && (r_beats_left == c_ONE_BEAT))) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Never pop while empty: the FIFO would corrupt its pointers.
    always_comb begin
        fifo_rd_en = 1'b0;
        if ((r_state == c_BURST) && (r_beats_left != '0) && !fifo_empty && w_out_free) begin
            fifo_rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_beats_left <= '0;
            r_first_beat <= 1'b0;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_m_sob      <= 1'b0;
            r_m_eob      <= 1'b0;
            r_burst_cnt  <= '0;
        end else begin
            if ((r_state == c_IDLE) && (w_state_nxt == c_BURST)) begin
                r_beats_left <= w_beats_init;
                r_first_beat <= 1'b1;
            end
            if (fifo_rd_en) begin
                r_m_data     <= fifo_rd_data;
                r_m_valid    <= 1'b1;
                r_m_sob      <= r_first_beat;
                r_m_eob      <= (r_beats_left == c_ONE_BEAT);
                r_beats_left <= r_beats_left - c_ONE_BEAT;
                r_first_beat <= 1'b0;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
                r_m_sob   <= 1'b0;
                r_m_eob   <= 1'b0;
            end
            if (r_m_valid && m_ready && r_m_eob) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
        end
    end

    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;
    assign m_sob     = r_m_sob;
    assign m_eob     = r_m_eob;
    assign busy      = (r_state == c_BURST) || r_m_valid;
    assign burst_cnt = r_burst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Self-checking bench for fifo_burst_reader with a FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic        fifo_rd_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_sob;
    logic        m_eob;
    logic        busy;
    logic [15:0] burst_cnt;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .BURST_LEN  (4),
        .TIMEOUT    (16)
    ) u_dut (
        .clk          (clk),
        .arst         (arst),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .fifo_rd_en   (fifo_rd_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sob        (m_sob),
        .m_eob        (m_eob),
        .busy         (busy),
        .burst_cnt    (burst_cnt)
    );

    // Fall-through FIFO model; ovr_en fakes a stale count to provoke underflow.
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       push = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       ovr_en = 1'b0;
    logic [4:0] ovr_val = 5'd0;

    always @(posedge clk) begin
        if (push) begin
            mem[wr_ptr % 64] <= push_data;
            wr_ptr <= wr_ptr + 1;
        end
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rd_en && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
    end

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_count   = ovr_en ? ovr_val : 5'(wr_ptr - rd_ptr);
    assign fifo_rd_data = mem[rd_ptr % 64];

    int         cap_n = 0;
    int         pops = 0;
    int         empty_pops = 0;
    logic [7:0] cap_data [0:63];
    logic       cap_sob  [0:63];
    logic       cap_eob  [0:63];

    always @(negedge clk) begin
        if (!arst) begin
            if (fifo_rd_en) begin
                pops++;
                if (fifo_empty) empty_pops++;
            end
            if (m_valid && m_ready && cap_n < 64) begin
                cap_data[cap_n] = m_data;
                cap_sob[cap_n]  = m_sob;
                cap_eob[cap_n]  = m_eob;
                cap_n++;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_words(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push = 1'b1;
            push_data = base + 8'(i);
            step();
        end
        push = 1'b0;
    endtask

    task automatic wait_caps(input string nm, input int target);
        for (int i = 0; i < 40 && cap_n < target; i++) step();
        check({nm, "_done"}, 32'(cap_n >= target), 32'd1);
    endtask

    task automatic check_beat(input string nm, input int idx, input logic [7:0] d,
                              input logic s, input logic e);
        check({nm, "_data"}, 32'(cap_data[idx]), 32'(d));
        check({nm, "_sob"},  32'(cap_sob[idx]),  32'(s));
        check({nm, "_eob"},  32'(cap_eob[idx]),  32'(e));
    endtask

    typedef struct packed {
        logic       ready;
        logic       valid;
        logic [7:0] data;
        logic       sob;
        logic       eob;
        logic       rd_en;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int p0;
        int lat;
        logic found;

        // Backpressure table: m_ready low for the first 5 valid cycles.
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        // T1: reset held with 8 words available
        arst = 1'b1;
        push_words(8'h10, 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_rd_en", 32'(fifo_rd_en), 32'd0);
            check("t1_valid", 32'(m_valid), 32'd0);
            check("t1_bcnt",  32'(burst_cnt), 32'd0);
            check("t1_busy",  32'(busy), 32'd0);
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        arst = 1'b0;
        step();
        check("t1_post_busy", 32'(busy), 32'd0);

        // T2: full burst, consumer always ready
        m_ready = 1'b1;
        base = cap_n;
        p0 = pops;
        push_words(8'hA0, 4);
        wait_caps("t2", base + 4);
        steps(2);
        check_beat("t2_b0", base + 0, 8'hA0, 1'b1, 1'b0);
        check_beat("t2_b1", base + 1, 8'hA1, 1'b0, 1'b0);
        check_beat("t2_b2", base + 2, 8'hA2, 1'b0, 1'b0);
        check_beat("t2_b3", base + 3, 8'hA3, 1'b0, 1'b1);
        check("t2_pops", 32'(pops - p0), 32'd4);
        check("t2_bcnt", 32'(burst_cnt), 32'd1);
        check("t2_idle", 32'(busy), 32'd0);

        // T3: backpressure, cycle-exact table
        m_ready = 1'b0;
        p0 = pops;
        push_words(8'hA0, 4);
        for (int r = 0; r < 12; r++) begin
            m_ready = tbl[r].ready;
            @(negedge clk);
            check($sformatf("t3_r%0d_valid", r), 32'(m_valid), 32'(tbl[r].valid));
            check($sformatf("t3_r%0d_rd_en", r), 32'(fifo_rd_en), 32'(tbl[r].rd_en));
            check($sformatf("t3_r%0d_sob", r), 32'(m_sob), 32'(tbl[r].sob));
            check($sformatf("t3_r%0d_eob", r), 32'(m_eob), 32'(tbl[r].eob));
            if (tbl[r].valid) check($sformatf("t3_r%0d_data", r), 32'(m_data), 32'(tbl[r].data));
            step();
        end
        check("t3_pops", 32'(pops - p0), 32'd4);
        check("t3_bcnt", 32'(burst_cnt), 32'd2);

        // T4: stale count of 4 with only 2 words present -> stall, then refill
        m_ready = 1'b1;
        base = cap_n;
        p0 = pops;
        push_words(8'hB0, 2);
        ovr_val = 5'd4;
        ovr_en = 1'b1;
        steps(8);
        check("t4_stall_beats", 32'(cap_n - base), 32'd2);
        check("t4_stall_pops",  32'(pops - p0), 32'd2);
        check("t4_stall_busy",  32'(busy), 32'd1);
        ovr_en = 1'b0;
        push_words(8'hB2, 2);
        wait_caps("t4", base + 4);
        steps(2);
        check_beat("t4_b0", base + 0, 8'hB0, 1'b1, 1'b0);
        check_beat("t4_b1", base + 1, 8'hB1, 1'b0, 1'b0);
        check_beat("t4_b2", base + 2, 8'hB2, 1'b0, 1'b0);
        check_beat("t4_b3", base + 3, 8'hB3, 1'b0, 1'b1);
        check("t4_bcnt", 32'(burst_cnt), 32'd3);

        // T5: 3 residual words
        base = cap_n;
        p0 = pops;
        push_words(8'hC0, 3);
`ifdef FLUSH_TIMEOUT_EN
        // Timer counts 0..15 from the first write; BURST entered 16 edges later.
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                lat = n;
                break;
            end
            step();
        end
        check("t5_flush_latency", 32'(lat), 32'd14);
        wait_caps("t5", base + 3);
        steps(2);
        check_beat("t5_b0", base + 0, 8'hC0, 1'b1, 1'b0);
        check_beat("t5_b1", base + 1, 8'hC1, 1'b0, 1'b0);
        check_beat("t5_b2", base + 2, 8'hC2, 1'b0, 1'b1);
        check("t5_bcnt", 32'(burst_cnt), 32'd4);
`else
        lat = 0;
        steps(100);
        check("t5_no_beats", 32'(cap_n - base), 32'd0);
        check("t5_no_pops",  32'(pops - p0), 32'd0);
        check("t5_bcnt",     32'(burst_cnt), 32'd3);
        check("t5_busy",     32'(busy), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
`endif

        // T6: async reset right after beat 2 is accepted (beat 3 already loaded)
        base = cap_n;
        push_words(8'hD0, 4);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid && m_ready && m_data == 8'hD1) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reach_beat2", 32'(found), 32'd1);
        step();
        arst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(m_valid), 32'd0);
        check("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t6_rst_busy",  32'(busy), 32'd0);
        check("t6_rst_bcnt",  32'(burst_cnt), 32'd0);
        steps(2);
        arst = 1'b0;
        p0 = pops;
        steps(8);
        check("t6_idle_pops",  32'(pops - p0), 32'd0);
        check("t6_idle_beats", 32'(cap_n - base), 32'd2);
        check("t6_idle_busy",  32'(busy), 32'd0);
        push_words(8'hE0, 3);
        wait_caps("t6", base + 6);
        steps(2);
        check_beat("t6_b0", base + 2, 8'hD3, 1'b1, 1'b0);
        check_beat("t6_b1", base + 3, 8'hE0, 1'b0, 1'b0);
        check_beat("t6_b2", base + 4, 8'hE1, 1'b0, 1'b0);
        check_beat("t6_b3", base + 5, 8'hE2, 1'b0, 1'b1);
        check("t6_bcnt", 32'(burst_cnt), 32'd1);

        check("no_pop_while_empty", 32'(empty_pops), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
